// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl_if
// Purpose  : Control/handshake bundle between the multicycle controller and
//            its datapath/memory. The master modport is the controller side.
// Options  : MCTRL_BRANCH_EN adds the branch_sel strobe.
// Revision : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_if;
  logic        run;
  logic [31:0] instr;
  logic        mem_ready;
  logic        alu_zero;
  logic        mem_req;
  logic        mem_we;
  logic        addr_sel;
  logic        ir_we;
  logic        pc_we;
  logic        reg_we;
  logic        alu_src_imm;
  logic        wb_sel_mem;
  logic [6:0]  imm_typ;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [15:0] instret;
`ifdef MCTRL_BRANCH_EN
  logic        branch_sel;
`endif

  modport master (
    input  run, instr, mem_ready, alu_zero,
    output mem_req, mem_we, addr_sel, ir_we, pc_we, reg_we, alu_src_imm,
           wb_sel_mem, imm_typ, trap, trap_cause, instret
`ifdef MCTRL_BRANCH_EN
    , output branch_sel
`endif
  );

  modport slave (
    output run, instr, mem_ready, alu_zero,
    input  mem_req, mem_we, addr_sel, ir_we, pc_we, reg_we, alu_src_imm,
           wb_sel_mem, imm_typ, trap, trap_cause, instret
`ifdef MCTRL_BRANCH_EN
    , input branch_sel
`endif
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Multicycle CPU control FSM (IDLE/FETCH/DECODE/EXEC/MEM/WB/TRAP)
//            with memory wait timeout, sticky traps and a retired-instruction
//            counter.
// Options  : define MCTRL_BRANCH_EN to accept opcode 1100011 via a BRANCH
//            state; otherwise that opcode traps as illegal.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
  parameter int MEM_WAIT_MAX = 15
) (
  input wire                clk,
  input wire                rst_n,
  multicycle_ctrl_if.master bus
);

  localparam logic [6:0] C_OP_IMM    = 7'b0010011;
  localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OP_STORE  = 7'b0100011;
  localparam logic [6:0] C_OP_REG    = 7'b0110011;
`ifdef MCTRL_BRANCH_EN
  localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
`endif
  // Counter value that, with mem_ready still low, completes the allowed wait.
  localparam logic [3:0] C_WAIT_LAST     = 4'(MEM_WAIT_MAX - 1);
  localparam logic [1:0] C_CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] C_CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
`ifdef MCTRL_BRANCH_EN
    S_BRANCH = 3'd7,
`endif
    S_TRAP   = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [15:0] instret_q, instret_d;
  logic [1:0]  cause_q, cause_d;

  logic       w_mem_req, w_mem_we, w_addr_sel, w_ir_we, w_pc_we, w_reg_we;
  logic       w_alu_src_imm, w_wb_sel_mem;
  logic [6:0] w_imm_typ;
`ifdef MCTRL_BRANCH_EN
  logic       w_branch_sel;
  logic       w_is_branch;
`endif

  logic [6:0] w_op;
  logic       w_is_imm, w_is_load, w_is_store, w_is_reg, w_legal;
  logic [6:0] w_legal_op;
  logic       w_unused;

  // Opcode classification; instr is stable from DECODE until retirement.
  assign w_op       = bus.instr[6:0];
  assign w_is_imm   = (w_op == C_OP_IMM);
  assign w_is_load  = (w_op == C_OP_LOAD);
  assign w_is_store = (w_op == C_OP_STORE);
  assign w_is_reg   = (w_op == C_OP_REG);
`ifdef MCTRL_BRANCH_EN
  assign w_is_branch = (w_op == C_OP_BRANCH);
  assign w_legal     = w_is_imm | w_is_load | w_is_store | w_is_reg | w_is_branch;
`else
  assign w_legal     = w_is_imm | w_is_load | w_is_store | w_is_reg;
`endif
  assign w_legal_op = w_legal ? w_op : 7'd0;
  assign w_unused   = ^{bus.alu_zero, bus.instr[31:7]};

  // Next-state, counters and decoded strobes for the current state.
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    instret_d     = instret_q;
    cause_d       = cause_q;
    w_mem_req     = 1'b0;
    w_mem_we      = 1'b0;
    w_addr_sel    = 1'b0;
    w_ir_we       = 1'b0;
    w_pc_we       = 1'b0;
    w_reg_we      = 1'b0;
    w_alu_src_imm = 1'b0;
    w_wb_sel_mem  = 1'b0;
    w_imm_typ     = 7'd0;
`ifdef MCTRL_BRANCH_EN
    w_branch_sel  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.run) begin
          state_d = S_FETCH;
          wait_d  = 4'd0;
        end
      end
      S_FETCH: begin
        w_mem_req = 1'b1;
        // Completion is checked first so a late ready still beats the timeout.
        if (bus.mem_ready) begin
          w_ir_we = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == C_WAIT_LAST) begin
          state_d = S_TRAP;
          cause_d = C_CAUSE_TIMEOUT;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      S_DECODE: begin
        w_imm_typ = w_legal_op;
        if (w_legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = C_CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        w_imm_typ     = w_legal_op;
        w_alu_src_imm = w_is_imm | w_is_load | w_is_store;
        if (w_is_load || w_is_store) begin
          state_d = S_MEM;
          wait_d  = 4'd0;
`ifdef MCTRL_BRANCH_EN
        end else if (w_is_branch) begin
          state_d = S_BRANCH;
`endif
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        w_imm_typ  = w_legal_op;
        w_mem_req  = 1'b1;
        w_addr_sel = 1'b1;
        w_mem_we   = w_is_store;
        if (bus.mem_ready) begin
          if (w_is_store) begin
            // Stores retire directly out of MEM.
            w_pc_we   = 1'b1;
            instret_d = instret_q + 16'd1;
            state_d   = bus.run ? S_FETCH : S_IDLE;
            wait_d    = 4'd0;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == C_WAIT_LAST) begin
          state_d = S_TRAP;
          cause_d = C_CAUSE_TIMEOUT;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      S_WB: begin
        w_imm_typ    = w_legal_op;
        w_reg_we     = 1'b1;
        w_wb_sel_mem = w_is_load;
        w_pc_we      = 1'b1;
        instret_d    = instret_q + 16'd1;
        state_d      = bus.run ? S_FETCH : S_IDLE;
        wait_d       = 4'd0;
      end
`ifdef MCTRL_BRANCH_EN
      S_BRANCH: begin
        w_pc_we      = 1'b1;
        w_branch_sel = bus.alu_zero;
        instret_d    = instret_q + 16'd1;
        state_d      = bus.run ? S_FETCH : S_IDLE;
        wait_d       = 4'd0;
      end
`endif
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, wait counter, retired count and trap cause registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wait_q    <= 4'd0;
      instret_q <= 16'd0;
      cause_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
      cause_q   <= cause_d;
    end
  end

  assign bus.mem_req     = w_mem_req;
  assign bus.mem_we      = w_mem_we;
  assign bus.addr_sel    = w_addr_sel;
  assign bus.ir_we       = w_ir_we;
  assign bus.pc_we       = w_pc_we;
  assign bus.reg_we      = w_reg_we;
  assign bus.alu_src_imm = w_alu_src_imm;
  assign bus.wb_sel_mem  = w_wb_sel_mem;
  assign bus.imm_typ     = w_imm_typ;
  assign bus.trap        = (state_q == S_TRAP);
  assign bus.trap_cause  = cause_q;
  assign bus.instret     = instret_q;
`ifdef MCTRL_BRANCH_EN
  assign bus.branch_sel  = w_branch_sel;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Purpose  : Self-checking bench for multicycle_ctrl: a directed vector
//            table, hand-written timeout/reset/branch sequences and random
//            instruction streams predicted from per-phase durations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  localparam int MAXW = 15;
  localparam logic [6:0] OP_I = 7'h13, OP_L = 7'h03, OP_S = 7'h23, OP_R = 7'h33;
  localparam logic [7:0] B_MREQ = 8'h80, B_MWE = 8'h40, B_ASEL = 8'h20, B_IRWE = 8'h10;
  localparam logic [7:0] B_PCWE = 8'h08, B_REGWE = 8'h04, B_AIMM = 8'h02, B_WBSEL = 8'h01;

  typedef struct {
    string       name;
    logic        run;
    logic [31:0] instr;
    logic        rdy;
    logic        az;
    logic [7:0]  strb;
    logic [6:0]  typ;
    logic        trap;
    logic [1:0]  cause;
    logic [15:0] ret;
  } vec_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  int          tests = 0;
  int          fails = 0;
  logic [15:0] mret;
  vec_t        q[$];
  vec_t        tbl[23];

  multicycle_ctrl_if bus();

  multicycle_ctrl #(.MEM_WAIT_MAX(MAXW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(string nm, logic run, logic [31:0] ins, logic rdy,
                              logic [7:0] strb, logic [6:0] typ, logic trap,
                              logic [1:0] cause, logic [15:0] ret);
    vec_t v;
    v.name = nm; v.run = run; v.instr = ins; v.rdy = rdy; v.az = 1'($urandom());
    v.strb = strb; v.typ = typ; v.trap = trap; v.cause = cause; v.ret = ret;
    return v;
  endfunction

  function automatic logic [33:0] act_bits();
    return {bus.mem_req, bus.mem_we, bus.addr_sel, bus.ir_we, bus.pc_we, bus.reg_we,
            bus.alu_src_imm, bus.wb_sel_mem, bus.imm_typ, bus.trap, bus.trap_cause,
            bus.instret};
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    bus.run = v.run; bus.instr = v.instr; bus.mem_ready = v.rdy; bus.alu_zero = v.az;
  endtask

  // Entered one time unit after a rising edge; leaves at the same point of the next cycle.
  task automatic run_vec(vec_t v, int idx);
    drive(v);
    #4;
    chk($sformatf("%s[%0d]", v.name, idx), act_bits(),
        {v.strb, v.typ, v.trap, v.cause, v.ret});
    @(posedge clk); #1;
  endtask

  task automatic apply_q();
    foreach (q[i]) run_vec(q[i], i);
    q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; bus.run = 1'b0; bus.mem_ready = 1'b0; bus.instr = 32'd0; bus.alu_zero = 1'b0;
    #1;
    chk("reset_outputs", act_bits(), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mret = 16'd0;
    q.delete();
  endtask

  // Reference: one instruction as a list of phases with durations fixed by
  // its opcode and the number of low-ready cycles in each memory phase.
  task automatic gen_instr(input logic [6:0] op, input int wf, input int wm, input bit drop);
    logic [31:0] ins;
    logic        late_run;
    bit          is_l, is_s;
    ins = $urandom(); ins[6:0] = op;
    late_run = !drop;
    is_l = (op == OP_L); is_s = (op == OP_S);
    for (int k = 0; k <= wf; k++)
      q.push_back(mk("fetch", 1'b1, $urandom(), (k == wf),
                     B_MREQ | ((k == wf) ? B_IRWE : 8'h00), 7'd0, 1'b0, 2'b00, mret));
    q.push_back(mk("decode", 1'b1, ins, 1'($urandom()), 8'h00, op, 1'b0, 2'b00, mret));
    q.push_back(mk("exec", late_run, ins, 1'($urandom()),
                   (op == OP_R) ? 8'h00 : B_AIMM, op, 1'b0, 2'b00, mret));
    if (is_l || is_s)
      for (int k = 0; k <= wm; k++)
        q.push_back(mk("mem", late_run, ins, (k == wm),
                       B_MREQ | B_ASEL | (is_s ? B_MWE : 8'h00) |
                       ((is_s && k == wm) ? B_PCWE : 8'h00), op, 1'b0, 2'b00, mret));
    if (!is_s)
      q.push_back(mk("wb", late_run, ins, 1'($urandom()),
                     B_PCWE | B_REGWE | (is_l ? B_WBSEL : 8'h00), op, 1'b0, 2'b00, mret));
    mret = mret + 16'd1;
  endtask

  function automatic int pick_wait();
    return ($urandom_range(0, 7) == 0) ? MAXW - 1 : int'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [31:0] ii, ss, ll, xx, bb;
    logic [6:0]  ops[4];
    ii = 32'h00500093; ss = 32'h00102023; ll = 32'h00002083; xx = 32'h0000007F;
    bb = 32'h00000463;
    ops[0] = OP_I; ops[1] = OP_L; ops[2] = OP_S; ops[3] = OP_R;

    tbl[0]  = mk("t_idle",       1, ii, 0, 8'h00,                        7'h00, 0, 2'b00, 16'd0);
    tbl[1]  = mk("t_i_fetch",    1, ii, 1, B_MREQ | B_IRWE,              7'h00, 0, 2'b00, 16'd0);
    tbl[2]  = mk("t_i_decode",   1, ii, 0, 8'h00,                        7'h13, 0, 2'b00, 16'd0);
    tbl[3]  = mk("t_i_exec",     1, ii, 0, B_AIMM,                       7'h13, 0, 2'b00, 16'd0);
    tbl[4]  = mk("t_i_wb",       1, ii, 0, B_PCWE | B_REGWE,             7'h13, 0, 2'b00, 16'd0);
    tbl[5]  = mk("t_s_fetch",    1, ss, 1, B_MREQ | B_IRWE,              7'h00, 0, 2'b00, 16'd1);
    tbl[6]  = mk("t_s_decode",   1, ss, 0, 8'h00,                        7'h23, 0, 2'b00, 16'd1);
    tbl[7]  = mk("t_s_exec",     1, ss, 0, B_AIMM,                       7'h23, 0, 2'b00, 16'd1);
    tbl[8]  = mk("t_s_mem",      1, ss, 1, B_MREQ | B_MWE | B_ASEL | B_PCWE, 7'h23, 0, 2'b00, 16'd1);
    tbl[9]  = mk("t_l_fetch",    1, ll, 1, B_MREQ | B_IRWE,              7'h00, 0, 2'b00, 16'd2);
    tbl[10] = mk("t_l_decode",   1, ll, 0, 8'h00,                        7'h03, 0, 2'b00, 16'd2);
    tbl[11] = mk("t_l_exec",     1, ll, 0, B_AIMM,                       7'h03, 0, 2'b00, 16'd2);
    tbl[12] = mk("t_l_mem_wait", 0, ll, 0, B_MREQ | B_ASEL,              7'h03, 0, 2'b00, 16'd2);
    tbl[13] = mk("t_l_mem_wait", 0, ll, 0, B_MREQ | B_ASEL,              7'h03, 0, 2'b00, 16'd2);
    tbl[14] = mk("t_l_mem_wait", 0, ll, 0, B_MREQ | B_ASEL,              7'h03, 0, 2'b00, 16'd2);
    tbl[15] = mk("t_l_mem_done", 0, ll, 1, B_MREQ | B_ASEL,              7'h03, 0, 2'b00, 16'd2);
    tbl[16] = mk("t_l_wb",       0, ll, 0, B_PCWE | B_REGWE | B_WBSEL,   7'h03, 0, 2'b00, 16'd2);
    tbl[17] = mk("t_idle_stop",  0, ll, 1, 8'h00,                        7'h00, 0, 2'b00, 16'd3);
    tbl[18] = mk("t_idle_go",    1, xx, 0, 8'h00,                        7'h00, 0, 2'b00, 16'd3);
    tbl[19] = mk("t_x_fetch",    1, xx, 1, B_MREQ | B_IRWE,              7'h00, 0, 2'b00, 16'd3);
    tbl[20] = mk("t_x_decode",   1, xx, 1, 8'h00,                        7'h00, 0, 2'b00, 16'd3);
    tbl[21] = mk("t_trap",       1, xx, 1, 8'h00,                        7'h00, 1, 2'b01, 16'd3);
    tbl[22] = mk("t_trap_hold",  1, ii, 1, 8'h00,                        7'h00, 1, 2'b01, 16'd3);

    do_reset();
    foreach (tbl[i]) run_vec(tbl[i], i);

    // FETCH timeout: 15 consecutive low cycles, trap visible on the 16th.
    do_reset();
    q.push_back(mk("to_f_idle", 1, ii, 0, 8'h00, 7'd0, 0, 2'b00, 16'd0));
    for (int k = 0; k < MAXW; k++)
      q.push_back(mk("to_f_wait", 1, ii, 0, B_MREQ, 7'd0, 0, 2'b00, 16'd0));
    q.push_back(mk("to_f_trap", 1, ii, 1, 8'h00, 7'd0, 1, 2'b10, 16'd0));
    q.push_back(mk("to_f_hold", 1, ii, 1, 8'h00, 7'd0, 1, 2'b10, 16'd0));
    apply_q();

    // Ready arriving on the last allowed cycle wins in both FETCH and MEM.
    do_reset();
    q.push_back(mk("edge_idle", 1, ii, 0, 8'h00, 7'd0, 0, 2'b00, 16'd0));
    gen_instr(OP_L, MAXW - 1, MAXW - 1, 1'b1);
    q.push_back(mk("edge_after", 0, ii, 0, 8'h00, 7'd0, 0, 2'b00, 16'd1));
    apply_q();

    // MEM timeout on a load: instret untouched.
    do_reset();
    q.push_back(mk("to_m_idle",  1, ll, 0, 8'h00, 7'd0, 0, 2'b00, 16'd0));
    q.push_back(mk("to_m_fetch", 1, ll, 1, B_MREQ | B_IRWE, 7'd0, 0, 2'b00, 16'd0));
    q.push_back(mk("to_m_dec",   1, ll, 0, 8'h00, 7'h03, 0, 2'b00, 16'd0));
    q.push_back(mk("to_m_exec",  1, ll, 0, B_AIMM, 7'h03, 0, 2'b00, 16'd0));
    for (int k = 0; k < MAXW; k++)
      q.push_back(mk("to_m_wait", 1, ll, 0, B_MREQ | B_ASEL, 7'h03, 0, 2'b00, 16'd0));
    q.push_back(mk("to_m_trap", 1, ll, 1, 8'h00, 7'd0, 1, 2'b10, 16'd0));
    apply_q();

    // Asynchronous reset in the middle of a MEM wait.
    do_reset();
    q.push_back(mk("ar_idle", 1, ii, 0, 8'h00, 7'd0, 0, 2'b00, 16'd0));
    gen_instr(OP_I, 0, 0, 1'b0);
    q.push_back(mk("ar_fetch", 1, ll, 1, B_MREQ | B_IRWE, 7'd0, 0, 2'b00, 16'd1));
    q.push_back(mk("ar_dec",   1, ll, 0, 8'h00, 7'h03, 0, 2'b00, 16'd1));
    q.push_back(mk("ar_exec",  1, ll, 0, B_AIMM, 7'h03, 0, 2'b00, 16'd1));
    q.push_back(mk("ar_mem",   1, ll, 0, B_MREQ | B_ASEL, 7'h03, 0, 2'b00, 16'd1));
    q.push_back(mk("ar_mem",   1, ll, 0, B_MREQ | B_ASEL, 7'h03, 0, 2'b00, 16'd1));
    apply_q();
    bus.mem_ready = 1'b0;
    #2;
    chk("ar_mem_req_before", {63'd0, bus.mem_req}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_async_zero", act_bits(), 64'd0);

    // Branch opcode: accepted only in the branch-enabled build.
    do_reset();
    q.push_back(mk("br_idle",  1, bb, 0, 8'h00, 7'd0, 0, 2'b00, 16'd0));
    q.push_back(mk("br_fetch", 1, bb, 1, B_MREQ | B_IRWE, 7'd0, 0, 2'b00, 16'd0));
`ifdef MCTRL_BRANCH_EN
    q.push_back(mk("br_dec",   1, bb, 0, 8'h00, 7'h63, 0, 2'b00, 16'd0));
    q.push_back(mk("br_exec",  1, bb, 0, 8'h00, 7'h63, 0, 2'b00, 16'd0));
    apply_q();
    begin
      vec_t v;
      v = mk("br_branch", 0, bb, 0, B_PCWE, 7'd0, 0, 2'b00, 16'd0);
      v.az = 1'b1;
      drive(v);
      #4;
      chk("br_branch", act_bits(), {v.strb, v.typ, v.trap, v.cause, v.ret});
      chk("br_branch_sel", {63'd0, bus.branch_sel}, 64'd1);
      @(posedge clk); #1;
    end
    q.push_back(mk("br_after", 0, bb, 0, 8'h00, 7'd0, 0, 2'b00, 16'd1));
`else
    q.push_back(mk("br_dec",   1, bb, 0, 8'h00, 7'd0, 0, 2'b00, 16'd0));
    q.push_back(mk("br_trap",  1, bb, 1, 8'h00, 7'd0, 1, 2'b01, 16'd0));
`endif
    apply_q();

    // Random instruction streams, occasionally dropping run mid-instruction.
    do_reset();
    q.push_back(mk("rnd_idle", 1, $urandom(), 1'($urandom()), 8'h00, 7'd0, 0, 2'b00, 16'd0));
    for (int n = 0; n < 40; n++) begin
      bit drop;
      drop = ($urandom_range(0, 3) == 0) || (n == 39);
      gen_instr(ops[$urandom_range(0, 3)], pick_wait(), pick_wait(), drop);
      if (drop)
        q.push_back(mk("rnd_idle", (n != 39), $urandom(), 1'($urandom()),
                       8'h00, 7'd0, 0, 2'b00, mret));
    end
    apply_q();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
